// File: rtl/cdbus_csr_arb.sv
// cdbus_csr_arb: two-master arbiter in front of a single cdbus CSR port.
// Requests are accepted combinationally (waitrequest low) and replayed one
// cycle later as a registered command. Reads carry an owner tag through a
// fixed two-stage pipeline, so each response returns exactly 3 cycles after
// acceptance and goes only to the master that issued it. A master can keep
// exclusive ownership with mX_lock. The lock is bounded by LOCK_MAX cycles.

module cdbus_csr_arb #(
    parameter int A_WIDTH  = 4,
    parameter int D_WIDTH  = 32,
    parameter int LOCK_MAX = 64
) (
    input  logic               clk,
    input  logic               reset_n,

    // master 0
    input  logic [A_WIDTH-1:0] m0_address,
    input  logic               m0_read,
    input  logic               m0_write,
    input  logic [D_WIDTH-1:0] m0_writedata,
    input  logic               m0_lock,
    output logic               m0_waitrequest,
    output logic [D_WIDTH-1:0] m0_readdata,
    output logic               m0_readdatavalid,

    // master 1
    input  logic [A_WIDTH-1:0] m1_address,
    input  logic               m1_read,
    input  logic               m1_write,
    input  logic [D_WIDTH-1:0] m1_writedata,
    input  logic               m1_lock,
    output logic               m1_waitrequest,
    output logic [D_WIDTH-1:0] m1_readdata,
    output logic               m1_readdatavalid,

    // shared cdbus CSR port
    output logic               s_chip_select,
    output logic               s_read,
    output logic               s_write,
    output logic [A_WIDTH-1:0] s_address,
    output logic [D_WIDTH-1:0] s_writedata,
    input  logic [D_WIDTH-1:0] s_readdata
);

    // LOCK_MAX is at most 255, so an 8-bit counter always holds the limit.
    localparam int               CNT_W      = 8;
    localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(LOCK_MAX);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED0  = 2'd1,
        LOCKED1  = 2'd2
    } arb_state_t;

    arb_state_t       state;
    logic             rr_ptr;     // 0: master 0 wins a tie, 1: master 1 wins
    logic [CNT_W-1:0] lock_cnt;

    logic             req0;
    logic             req1;
    logic             lock_timeout;
    logic             grant0;
    logic             grant1;
    logic             grant_any;

    // fields of the accepted request, meaningful only when grant_any is high
    logic               acc_read;
    logic               acc_write;
    logic [A_WIDTH-1:0] acc_address;
    logic [D_WIDTH-1:0] acc_writedata;
    logic               acc_is_read;

    // read tag pipeline: stage 0 lines up with s_read, stage 1 with s_readdata
    logic [1:0] vld_pipe;
    logic [1:0] tag_pipe;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // In the cycle the lock counter reaches its limit, the owner is not served.
    // The bus is free again on the following edge.
    assign lock_timeout = (state != UNLOCKED) && (lock_cnt == LOCK_LIMIT);

    // Grant selection: round-robin when unlocked, owner-only when locked.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset_n) begin
            case (state)
                UNLOCKED: begin
                    if (req0 && req1) begin
                        grant0 = ~rr_ptr;
                        grant1 = rr_ptr;
                    end else begin
                        grant0 = req0;
                        grant1 = req1;
                    end
                end
                LOCKED0: grant0 = req0 & ~lock_timeout;
                LOCKED1: grant1 = req1 & ~lock_timeout;
                default: begin
                    grant0 = 1'b0;
                    grant1 = 1'b0;
                end
            endcase
        end
    end

    assign grant_any = grant0 | grant1;

    // A master that is idle never waits. Every request waits during reset.
    assign m0_waitrequest = ~reset_n | (req0 & ~grant0);
    assign m1_waitrequest = ~reset_n | (req1 & ~grant1);

    // Select the command of the granted master. Read+write together is a write.
    always_comb begin
        acc_read      = grant1 ? m1_read      : m0_read;
        acc_write     = grant1 ? m1_write     : m0_write;
        acc_address   = grant1 ? m1_address   : m0_address;
        acc_writedata = grant1 ? m1_writedata : m0_writedata;
        acc_is_read   = grant_any & acc_read & ~acc_write;
    end

    // Arbitration FSM: lock ownership, lock timeout counter, round-robin pointer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= UNLOCKED;
            rr_ptr   <= 1'b0;
            lock_cnt <= '0;
        end else begin
            // the master just served goes to the back of the queue
            if (grant_any)
                rr_ptr <= grant0;

            case (state)
                UNLOCKED: begin
                    if (grant0 && m0_lock) begin
                        state    <= LOCKED0;
                        lock_cnt <= '0;
                    end else if (grant1 && m1_lock) begin
                        state    <= LOCKED1;
                        lock_cnt <= '0;
                    end
                end
                LOCKED0: begin
                    if (!m0_lock || lock_timeout) begin
                        state    <= UNLOCKED;
                        lock_cnt <= '0;
                    end else if (lock_cnt != LOCK_LIMIT) begin
                        lock_cnt <= lock_cnt + CNT_W'(1);
                    end
                end
                LOCKED1: begin
                    if (!m1_lock || lock_timeout) begin
                        state    <= UNLOCKED;
                        lock_cnt <= '0;
                    end else if (lock_cnt != LOCK_LIMIT) begin
                        lock_cnt <= lock_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= UNLOCKED;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

    // Registered command to the CSR port. All fields are zero when nothing is issued.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s_chip_select <= 1'b0;
            s_read        <= 1'b0;
            s_write       <= 1'b0;
            s_address     <= '0;
            s_writedata   <= '0;
        end else begin
            s_chip_select <= grant_any;
            s_read        <= acc_is_read;
            s_write       <= grant_any & acc_write;
            s_address     <= grant_any ? acc_address   : '0;
            s_writedata   <= grant_any ? acc_writedata : '0;
        end
    end

    // Owner tag pipeline. Reset drops any reads still in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe[0] <= acc_is_read;
            tag_pipe[0] <= grant1;
            vld_pipe[1] <= vld_pipe[0];
            tag_pipe[1] <= tag_pipe[0];
        end
    end

    // Capture CSR read data and return it to the owning master only.
    // Readdata keeps its last value between strobes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
            m0_readdata      <= '0;
            m1_readdata      <= '0;
        end else begin
            m0_readdatavalid <= vld_pipe[1] & ~tag_pipe[1];
            m1_readdatavalid <= vld_pipe[1] &  tag_pipe[1];
            if (vld_pipe[1] && !tag_pipe[1])
                m0_readdata <= s_readdata;
            if (vld_pipe[1] && tag_pipe[1])
                m1_readdata <= s_readdata;
        end
    end

endmodule

// File: tb/tb_cdbus_csr_arb.sv
// Bench for cdbus_csr_arb. It contains a transaction-level model: owner and
// lock age as integers, and pending read responses in a queue with due cycles.
// The model is compared against the DUT on every falling edge. Directed
// scenarios add literal expectations. A simple CSR slave answers reads.

module tb_cdbus_csr_arb;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int LM = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] m0_address, m1_address;
    logic          m0_read, m0_write, m0_lock;
    logic          m1_read, m1_write, m1_lock;
    logic [DW-1:0] m0_writedata, m1_writedata;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic          s_chip_select, s_read, s_write;
    logic [AW-1:0] s_address;
    logic [DW-1:0] s_writedata;
    logic [DW-1:0] s_readdata = '0;

    cdbus_csr_arb #(.A_WIDTH(AW), .D_WIDTH(DW), .LOCK_MAX(LM)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_lock(m0_lock),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_lock(m1_lock),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_chip_select(s_chip_select), .s_read(s_read), .s_write(s_write),
        .s_address(s_address), .s_writedata(s_writedata), .s_readdata(s_readdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    // CSR contents seen by the slave: address 3 is a fixed pattern
    function automatic logic [31:0] slave_data(logic [AW-1:0] a);
        return (a == 4'd3) ? 32'h12345678 : {16'hC5A0, 12'h000, a};
    endfunction

    // CSR slave: read data is valid in the cycle after s_read, otherwise garbage
    always @(posedge clk)
        s_readdata <= s_read ? slave_data(s_address) : 32'h0BADF00D;

    // ---------------- model ----------------
    typedef struct {
        int          due;
        int          who;
        logic [31:0] data;
    } resp_t;

    resp_t         q[$];
    resp_t         r;
    int            cyc = 0;
    int            m_owner = -1;
    int            m_age = 0;
    int            m_ptr = 0;
    int            g;
    bit            armed = 0;
    logic          rq0, rq1, lk, gw, gr;
    logic [AW-1:0] ga;
    logic [DW-1:0] gwd;
    logic          e_cs, e_rd, e_wr, e_rv0, e_rv1;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_rd0, e_rd1;

    always @(negedge clk) begin
        if (armed) begin
            chk("s_chip_select", s_chip_select, e_cs);
            chk("s_read", s_read, e_rd);
            chk("s_write", s_write, e_wr);
            chk("s_address", s_address, e_addr);
            if (e_wr || !e_cs) chk("s_writedata", s_writedata, e_wd);
            chk("m0_readdatavalid", m0_readdatavalid, e_rv0);
            chk("m1_readdatavalid", m1_readdatavalid, e_rv1);
            chk("m0_readdata", m0_readdata, e_rd0);
            chk("m1_readdata", m1_readdata, e_rd1);
        end
        rq0 = m0_read | m0_write;
        rq1 = m1_read | m1_write;
        if (!reset_n) begin
            chk("m0_waitrequest_rst", m0_waitrequest, 1);
            chk("m1_waitrequest_rst", m1_waitrequest, 1);
            m_owner = -1; m_age = 0; m_ptr = 0;
            q.delete();
            e_cs = 0; e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0;
            e_rv0 = 0; e_rv1 = 0; e_rd0 = '0; e_rd1 = '0;
            armed = 1;
        end else begin
            g = -1;
            if (m_owner < 0) begin
                if (rq0 && rq1) g = m_ptr;
                else if (rq0) g = 0;
                else if (rq1) g = 1;
            end else if (m_age < LM) begin
                if ((m_owner == 0 && rq0) || (m_owner == 1 && rq1)) g = m_owner;
            end
            chk("m0_waitrequest", m0_waitrequest, (rq0 && g != 0));
            chk("m1_waitrequest", m1_waitrequest, (rq1 && g != 1));

            if (m_owner >= 0) begin
                lk = (m_owner == 0) ? m0_lock : m1_lock;
                if (!lk || m_age >= LM) begin m_owner = -1; m_age = 0; end
                else m_age++;
            end else if (g >= 0 && ((g == 0) ? m0_lock : m1_lock)) begin
                m_owner = g; m_age = 0;
            end
            if (g >= 0) m_ptr = 1 - g;

            gw  = (g == 1) ? m1_write     : m0_write;
            gr  = (g == 1) ? m1_read      : m0_read;
            ga  = (g == 1) ? m1_address   : m0_address;
            gwd = (g == 1) ? m1_writedata : m0_writedata;
            e_cs   = (g >= 0);
            e_wr   = e_cs && gw;
            e_rd   = e_cs && gr && !gw;
            e_addr = e_cs ? ga : '0;
            e_wd   = e_cs ? gwd : '0;
            if (e_rd) q.push_back('{cyc + 3, g, slave_data(ga)});
            e_rv0 = 0; e_rv1 = 0;
            if (q.size() > 0 && q[0].due == cyc + 1) begin
                r = q.pop_front();
                if (r.who == 0) begin e_rv0 = 1; e_rd0 = r.data; end
                else begin e_rv1 = 1; e_rd1 = r.data; end
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        m0_read = 0; m0_write = 0; m0_lock = 0; m0_address = '0; m0_writedata = '0;
        m1_read = 0; m1_write = 0; m1_lock = 0; m1_address = '0; m1_writedata = '0;
    endtask

    initial begin
        idle();
        // reset: requests wait, outputs at reset values
        tick(); m0_read = 1; #1; chk("rst_m0_wait", m0_waitrequest, 1);
        tick(); idle(); tick();
        reset_n = 1; #1;
        chk("rst_s_cs", s_chip_select, 0);
        chk("rst_s_addr", s_address, 0);
        chk("rst_m0_rdv", m0_readdatavalid, 0);
        chk("rst_m1_rd", m1_readdata, 0);
        chk("idle_m0_wait", m0_waitrequest, 0);
        tick();

        // both masters write continuously: m0,m1,m0,m1,...
        m0_write = 1; m0_address = 4'd1; m0_writedata = 32'hA0A00000;
        m1_write = 1; m1_address = 4'd2; m1_writedata = 32'hB1B10000;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("alt_m0_wait", m0_waitrequest, i % 2);
            chk("alt_m1_wait", m1_waitrequest, (i + 1) % 2);
            if (i > 0) begin
                chk("alt_s_write", s_write, 1);
                chk("alt_s_addr", s_address, (i % 2 == 1) ? 1 : 2);
            end
            tick();
        end
        idle();
        chk("alt_s_addr_last", s_address, 2);
        tick();

        // single m0 read at address 3, response 3 cycles later
        m0_read = 1; m0_address = 4'd3; #1; chk("rd_m0_wait", m0_waitrequest, 0);
        tick(); idle();
        chk("rd_s_read", s_read, 1); chk("rd_s_addr", s_address, 3);
        tick(); chk("rd_s_cs_drop", s_chip_select, 0);
        tick();
        chk("rd_m0_rdv", m0_readdatavalid, 1);
        chk("rd_m0_data", m0_readdata, 32'h12345678);
        chk("rd_m1_rdv", m1_readdatavalid, 0);
        tick();
        chk("rd_m0_rdv_off", m0_readdatavalid, 0);
        chk("rd_m0_hold", m0_readdata, 32'h12345678);

        // interleaved back-to-back reads from both masters
        m0_read = 1; m0_address = 4'd1; m1_read = 1; m1_address = 4'd2;
        repeat (3) tick();
        chk("il_m1_rdv", m1_readdatavalid, 1);
        chk("il_m1_data", m1_readdata, 32'hC5A00002);
        tick(); idle(); repeat (4) tick();

        // m1 locks; m0 waits until the edge after m1_lock drops
        m1_write = 1; m1_lock = 1; m1_address = 4'd7; m1_writedata = 32'h77;
        #1; chk("lk_m1_acc", m1_waitrequest, 0);
        tick(); m1_write = 0; m0_read = 1; m0_address = 4'd2;
        for (int i = 0; i < 5; i++) begin
            #1; chk("lk_m0_wait", m0_waitrequest, 1); tick();
        end
        m1_lock = 0; #1; chk("lk_m0_wait_rel", m0_waitrequest, 1);
        tick(); #1; chk("lk_m0_acc", m0_waitrequest, 0);
        tick(); idle(); repeat (3) tick();

        // m0 locks and goes quiet; the lock times out after LOCK_MAX cycles
        m0_write = 1; m0_lock = 1; m0_address = 4'd9; m0_writedata = 32'h99;
        #1; chk("to_m0_acc", m0_waitrequest, 0);
        tick(); m0_write = 0; m1_write = 1; m1_address = 4'd10; m1_writedata = 32'h1010;
        for (int i = 0; i < 8; i++) begin
            #1; chk("to_m1_wait", m1_waitrequest, 1); tick();
        end
        m0_write = 1; #1;
        chk("to_owner_not_served", m0_waitrequest, 1);
        chk("to_m1_wait_last", m1_waitrequest, 1);
        tick(); m0_lock = 0; #1;
        chk("to_m1_acc", m1_waitrequest, 0);
        chk("to_m0_wait2", m0_waitrequest, 1);
        tick(); #1; chk("to_m0_acc2", m0_waitrequest, 0);
        tick(); idle(); tick();

        // read+write together is a write, with no response
        m1_read = 1; m1_write = 1; m1_address = 4'd5; m1_writedata = 32'hA5;
        #1; chk("rw_m1_acc", m1_waitrequest, 0);
        tick(); idle();
        chk("rw_s_write", s_write, 1); chk("rw_s_read", s_read, 0);
        chk("rw_s_addr", s_address, 5); chk("rw_s_wd", s_writedata, 32'hA5);
        tick(); tick(); chk("rw_no_rdv", m1_readdatavalid, 0);
        tick();

        // reset while a read is in flight discards it
        m0_read = 1; m0_address = 4'd3; #1; chk("rr_m0_acc", m0_waitrequest, 0);
        tick(); idle(); reset_n = 0; #1;
        chk("rr_m0_wait_rst", m0_waitrequest, 1);
        chk("rr_m1_wait_rst", m1_waitrequest, 1);
        tick(); reset_n = 1;
        chk("rr_s_cs", s_chip_select, 0);
        chk("rr_s_read", s_read, 0);
        chk("rr_m0_rd", m0_readdata, 0);
        for (int i = 0; i < 4; i++) begin
            tick(); chk("rr_no_rdv", m0_readdatavalid, 0);
        end
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cdbus_csr_arb.md
CDBUS_CSR_ARB -- requirements
Module: cdbus_csr_arb

Interface
REQ-001 Parameters: A_WIDTH 4, CSR word address width; D_WIDTH 32, CSR data width; LOCK_MAX 64, lock-timeout in clk cycles (range 2..255).
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 reset_n  in  1  reset is synchronous and active-low.
REQ-004 mX_address  in  A_WIDTH  master X (X=0,1) CSR address.
REQ-005 mX_read / mX_write  in  1 each  master X access request, held until accepted.
REQ-006 mX_writedata  in  D_WIDTH  master X write data.
REQ-007 mX_lock  in  1  master X requests exclusive ownership across accesses.
REQ-008 mX_waitrequest  out  1  high = master X request not accepted this cycle.
REQ-009 mX_readdata  out  D_WIDTH  read return data to master X.
REQ-010 mX_readdatavalid  out  1  one-cycle strobe qualifying mX_readdata.
REQ-011 s_chip_select, s_read, s_write  out  1 each  registered command to the shared cdbus CSR port.
REQ-012 s_address  out  A_WIDTH; s_writedata  out  D_WIDTH  registered command fields.
REQ-013 s_readdata  in  D_WIDTH  cdbus CSR read data, valid the cycle after s_read high.

Function
REQ-014 Master X requests in a cycle when mX_read or mX_write is high; both high is treated as a write.
REQ-015 At most one request is accepted per cycle; the accepted master sees mX_waitrequest low that cycle, all other requesting masters see it high.
REQ-016 mX_waitrequest is low when master X has no request.
REQ-017 Arbitration state: UNLOCKED, LOCKED0, LOCKED1.
REQ-018 UNLOCKED, one requester: it is accepted.
REQ-019 UNLOCKED, both request: the master indicated by a round-robin pointer wins; pointer updates to the other master after every acceptance; pointer reset value selects master 0.
REQ-020 LOCKEDx: only master x may be accepted; the other master waits regardless of pointer.
REQ-021 UNLOCKED -> LOCKEDx when an accepted master x access has mX_lock high.
REQ-022 LOCKEDx -> UNLOCKED on the edge after any cycle where mx_lock is low (request or not), or when the lock counter reaches LOCK_MAX.
REQ-023 Lock counter clears on entering LOCKEDx, increments every cycle in LOCKEDx, saturates at LOCK_MAX; a timeout release does not accept a pending owner request in that cycle.
REQ-024 Accepted command in cycle N appears on s_* in cycle N+1 for exactly one cycle with s_chip_select high; s_* fields are 0 when no command is issued.
REQ-025 Back-to-back acceptance every cycle is supported; throughput one access per cycle.
REQ-026 Each read carries a 1-bit owner tag through a 2-stage pipeline; s_readdata is registered in cycle N+2 and presented as mX_readdata with mX_readdatavalid high in cycle N+3 to the owning master only.
REQ-027 Read latency from acceptance to readdatavalid is exactly 3 cycles, independent of interleaved traffic; responses are in issue order.
REQ-028 mX_readdata holds its last value when mX_readdatavalid is low.
REQ-029 Writes produce no response.

Reset
REQ-030 While reset_n is low at a rising edge: state UNLOCKED, pointer to master 0, lock counter 0, tag pipeline cleared.
REQ-031 Reset outputs: s_chip_select/s_read/s_write 0, s_address/s_writedata 0, mX_readdatavalid 0, mX_readdata 0.
REQ-032 mX_waitrequest is high while reset_n is low.
REQ-033 Reads in flight when reset asserts are discarded; no readdatavalid issues for them after reset releases.

Verification
REQ-034 m0 read addr 3, s_readdata 0x12345678 next cycle after s_read -> m0_readdatavalid high 3 cycles after accept with 0x12345678; m1 sees no strobe.
REQ-035 m0 and m1 writes held continuously for 6 cycles -> accepts alternate m0,m1,m0,m1,...; one s_write per cycle.
REQ-036 m1 write with m1_lock high, then m1_lock held 5 cycles while m0 requests -> m0 waits until edge after m1_lock low, then accepted.
REQ-037 m0 holds m0_lock high with no requests, LOCK_MAX=8 -> m1 accepted no earlier than 8 cycles after lock entry.
REQ-038 m0 read accepted, reset_n low on next cycle for 1 cycle -> no m0_readdatavalid afterward; all outputs at reset values.
REQ-039 m1 asserts read and write together, addr 5, data 0xA5 -> single s_write to addr 5 data 0xA5, no read response.
